l2_req_arbiter: RTL and testbench

//  Shares the single L2 cache request port between the I-side (fetch) and D-side (load/store) requesters.

---
 rtl/rave_mem_pkg.sv | 9 +
 rtl/l2_req_arbiter_if.sv | 27 ++
 rtl/l2_arb_pick.sv | 31 +++
 rtl/l2_req_arbiter.sv | 65 ++++++
 tb/tb_l2_req_arbiter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rave_mem_pkg.sv
// rave_mem_pkg: shared op encodings, requester ids and L2 arbiter state encoding.
package rave_mem_pkg;
  localparam logic [1:0] OP_RD  = 2'd0;
  localparam logic [1:0] OP_WR  = 2'd1;
  localparam logic [1:0] OP_RFO = 2'd2;
  localparam logic [1:0] OP_NOP = 2'd3;
  typedef enum logic {SRC_I, SRC_D} src_t;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} st_t;
endpackage

// File: rtl/l2_req_arbiter_if.sv
// l2_req_arbiter_if: I/D request, response and L2 port bundle; slave = arbiter side.
interface l2_req_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 512,
  parameter int OP_W   = 2
);
  logic              i_req_valid, i_req_ready, d_req_valid, d_req_ready;
  logic [OP_W-1:0]   i_req_op, d_req_op, l2_req_op;
  logic [ADDR_W-1:0] i_req_addr, d_req_addr, l2_req_addr;
  logic [LINE_W-1:0] i_req_data, d_req_data, l2_req_data;
  logic              i_resp_valid, d_resp_valid, l2_req_valid, l2_req_ready, l2_resp_valid, busy;
  logic [LINE_W-1:0] i_resp_data, d_resp_data, l2_resp_data;
  modport slave (
    input  i_req_valid, i_req_op, i_req_addr, i_req_data,
    input  d_req_valid, d_req_op, d_req_addr, d_req_data,
    input  l2_req_ready, l2_resp_valid, l2_resp_data,
    output i_req_ready, d_req_ready, i_resp_valid, i_resp_data, d_resp_valid, d_resp_data,
    output l2_req_valid, l2_req_op, l2_req_addr, l2_req_data, busy
  );
  modport master (
    output i_req_valid, i_req_op, i_req_addr, i_req_data,
    output d_req_valid, d_req_op, d_req_addr, d_req_data,
    output l2_req_ready, l2_resp_valid, l2_resp_data,
    input  i_req_ready, d_req_ready, i_resp_valid, i_resp_data, d_resp_valid, d_resp_data,
    input  l2_req_valid, l2_req_op, l2_req_addr, l2_req_data, busy
  );
endinterface

// File: rtl/l2_arb_pick.sv
// l2_arb_pick: D-over-I winner select; L2ARB_STARVE_GUARD_EN adds an I starvation guard.
module l2_arb_pick #(
  parameter int STARVE_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic i_valid,
  input  logic d_valid,
  output logic i_win,
  output logic d_win
);
`ifdef L2ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic starve;
  always_comb begin
    starve = cnt_q == CW'(STARVE_MAX);
    i_win  = i_valid & (~d_valid | starve);
    d_win  = d_valid & ~i_win;
    // streak breaks on an I grant or on a D grant with nobody waiting on the I side
    cnt_d  = !(en & (i_win | d_win)) ? cnt_q : (i_win | ~i_valid) ? '0 : starve ? cnt_q : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
`else
  logic unused_pick;
  assign unused_pick = ^{clk, rst, en, STARVE_MAX[0]};
  assign i_win = i_valid & ~d_valid;
  assign d_win = d_valid;
`endif
endmodule

// File: rtl/l2_req_arbiter.sv
// l2_req_arbiter: blocking I/D arbiter onto the single L2 request port, routes the response back.
// Optional I starvation guard under L2ARB_STARVE_GUARD_EN (see l2_arb_pick).
module l2_req_arbiter import rave_mem_pkg::*; #(
  parameter int ADDR_W     = 32,
  parameter int LINE_W     = 512,
  parameter int OP_W       = 2,
  parameter int STARVE_MAX = 8
) (
  input logic clk,
  input logic rst,
  l2_req_arbiter_if.slave bus
);
  st_t state_q, state_d;
  src_t owner_q, owner_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] data_q, data_d;
  logic idle, grant, hit, i_win, d_win;
  l2_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .clk(clk), .rst(rst), .en(idle),
    .i_valid(bus.i_req_valid), .d_valid(bus.d_req_valid),
    .i_win(i_win), .d_win(d_win)
  );
  always_ff @(posedge clk) state_q <= rst ? ST_IDLE : state_d;
  always_comb begin
    state_d = (state_q == ST_IDLE  && (i_win || d_win))   ? ST_ISSUE :
              (state_q == ST_ISSUE && bus.l2_req_ready)  ? ST_WAIT  :
              (state_q == ST_WAIT  && bus.l2_resp_valid) ? ST_IDLE  : state_q;
  end
  always_comb begin
    idle             = state_q == ST_IDLE;
    grant            = idle & (i_win | d_win);
    hit              = (state_q == ST_WAIT) & bus.l2_resp_valid;
    bus.i_req_ready  = idle & i_win;
    bus.d_req_ready  = idle & d_win;
    bus.l2_req_valid = state_q == ST_ISSUE;
    bus.l2_req_op    = op_q;
    bus.l2_req_addr  = addr_q;
    bus.l2_req_data  = data_q;
    bus.i_resp_valid = hit & (owner_q == SRC_I);
    bus.d_resp_valid = hit & (owner_q == SRC_D);
    bus.i_resp_data  = bus.i_resp_valid ? bus.l2_resp_data : '0;
    bus.d_resp_data  = bus.d_resp_valid ? bus.l2_resp_data : '0;
    bus.busy         = !idle;
  end
  always_comb begin
    owner_d = !grant ? owner_q : i_win ? SRC_I : SRC_D;
    op_d    = !grant ? op_q    : i_win ? bus.i_req_op   : bus.d_req_op;
    addr_d  = !grant ? addr_q  : i_win ? bus.i_req_addr : bus.d_req_addr;
    data_d  = !grant ? data_q  : i_win ? bus.i_req_data : bus.d_req_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= SRC_D;
      op_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      owner_q <= owner_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: tb/tb_l2_req_arbiter.sv
// tb_l2_req_arbiter: table vectors, hand-written corner sequences and a queue-based random reference.
module tb_l2_req_arbiter;
  import rave_mem_pkg::*;
  localparam int SM = 2;
`ifdef L2ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam logic [511:0] PAT  = {16{32'hA5A5A5A5}};
  localparam logic [511:0] IDAT = {16{32'h11111111}};
  localparam logic [511:0] DDAT = {16{32'h0BADF00D}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l2_req_arbiter_if bus();
  l2_req_arbiter #(.STARVE_MAX(SM)) dut (.clk(clk), .rst(rst), .bus(bus));

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [1:0]  vld;
    logic [31:0] ia, da;
    logic [1:0]  l2;
    logic [5:0]  e;
    logic [31:0] ea;
    logic [1:0]  eop;
  } vec_t;

  typedef struct {
    src_t         src;
    logic [1:0]   op;
    logic [31:0]  addr;
    logic [511:0] data;
  } txn_t;

  function automatic vec_t mk(logic [1:0] vld, logic [31:0] ia, logic [31:0] da, logic [1:0] l2,
                              logic [5:0] e, logic [31:0] ea, logic [1:0] eop);
    vec_t v;
    v.vld = vld; v.ia = ia; v.da = da; v.l2 = l2; v.e = e; v.ea = ea; v.eop = eop;
    return v;
  endfunction

  function automatic logic [511:0] rline();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic txn_t newtxn(src_t s);
    txn_t t;
    t.src = s; t.op = 2'($urandom_range(3)); t.addr = $urandom; t.data = rline();
    return t;
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] want);
    nvec++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.i_req_valid = 1'b0; bus.i_req_op = OP_RD; bus.i_req_addr = '0; bus.i_req_data = IDAT;
    bus.d_req_valid = 1'b0; bus.d_req_op = OP_WR; bus.d_req_addr = '0; bus.d_req_data = DDAT;
    bus.l2_req_ready = 1'b0; bus.l2_resp_valid = 1'b0; bus.l2_resp_data = PAT;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    quiet();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[12];
    txn_t to_l2[$];
    txn_t to_resp[$];
    txn_t pi, pd;
    logic piv, pdv, lr, rv, iwin, dwin, idle_m, want_i;
    int streak;
    tbl = '{
      mk(2'b10, 32'h1000, 32'h0,    2'b00, 6'b100000, 32'h0,    OP_RD),
      mk(2'b00, 32'h0,    32'h0,    2'b10, 6'b001100, 32'h1000, OP_RD),
      mk(2'b00, 32'h0,    32'h0,    2'b00, 6'b000100, 32'h0,    OP_RD),
      mk(2'b00, 32'h0,    32'h0,    2'b01, 6'b000110, 32'h0,    OP_RD),
      mk(2'b00, 32'h0,    32'h0,    2'b00, 6'b000000, 32'h0,    OP_RD),
      mk(2'b11, 32'h2000, 32'h3000, 2'b00, 6'b010000, 32'h0,    OP_RD),
      mk(2'b10, 32'h2000, 32'h0,    2'b10, 6'b001100, 32'h3000, OP_WR),
      mk(2'b10, 32'h2000, 32'h0,    2'b01, 6'b000101, 32'h0,    OP_RD),
      mk(2'b10, 32'h2000, 32'h0,    2'b00, 6'b100000, 32'h0,    OP_RD),
      mk(2'b00, 32'h0,    32'h0,    2'b10, 6'b001100, 32'h2000, OP_RD),
      mk(2'b00, 32'h0,    32'h0,    2'b01, 6'b000110, 32'h0,    OP_RD),
      mk(2'b00, 32'h0,    32'h0,    2'b00, 6'b000000, 32'h0,    OP_RD)
    };
    do_reset();
    @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_iready", bus.i_req_ready, 1'b0);
    chk("rst_dready", bus.d_req_ready, 1'b0);
    chk("rst_l2v", bus.l2_req_valid, 1'b0);
    chk("rst_l2op", bus.l2_req_op, 2'd0);
    chk("rst_l2addr", bus.l2_req_addr, 32'h0);
    chk("rst_l2data", bus.l2_req_data, 512'h0);
    chk("rst_irv", bus.i_resp_valid, 1'b0);
    chk("rst_drv", bus.d_resp_valid, 1'b0);
    chk("rst_irdata", bus.i_resp_data, 512'h0);
    chk("rst_drdata", bus.d_resp_data, 512'h0);
    tick();

    foreach (tbl[n]) begin
      bus.i_req_valid = tbl[n].vld[1]; bus.i_req_addr = tbl[n].ia;
      bus.d_req_valid = tbl[n].vld[0]; bus.d_req_addr = tbl[n].da;
      bus.l2_req_ready = tbl[n].l2[1]; bus.l2_resp_valid = tbl[n].l2[0];
      @(negedge clk);
      chk($sformatf("t%0d_iready", n), bus.i_req_ready, tbl[n].e[5]);
      chk($sformatf("t%0d_dready", n), bus.d_req_ready, tbl[n].e[4]);
      chk($sformatf("t%0d_l2v", n), bus.l2_req_valid, tbl[n].e[3]);
      chk($sformatf("t%0d_busy", n), bus.busy, tbl[n].e[2]);
      chk($sformatf("t%0d_irv", n), bus.i_resp_valid, tbl[n].e[1]);
      chk($sformatf("t%0d_drv", n), bus.d_resp_valid, tbl[n].e[0]);
      chk($sformatf("t%0d_irdata", n), bus.i_resp_data, tbl[n].e[1] ? PAT : 512'h0);
      chk($sformatf("t%0d_drdata", n), bus.d_resp_data, tbl[n].e[0] ? PAT : 512'h0);
      if (tbl[n].e[3]) begin
        chk($sformatf("t%0d_l2addr", n), bus.l2_req_addr, tbl[n].ea);
        chk($sformatf("t%0d_l2op", n), bus.l2_req_op, tbl[n].eop);
      end
      tick();
    end

    quiet();
    bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h4000;
    @(negedge clk);
    chk("bp_grant", bus.d_req_ready, 1'b1);
    tick();
    for (int k = 0; k < 5; k++) begin
      bus.i_req_valid = 1'b1; bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h0;
      @(negedge clk);
      chk("bp_l2v", bus.l2_req_valid, 1'b1);
      chk("bp_addr", bus.l2_req_addr, 32'h4000);
      chk("bp_op", bus.l2_req_op, OP_WR);
      chk("bp_data", bus.l2_req_data, DDAT);
      chk("bp_iready", bus.i_req_ready, 1'b0);
      chk("bp_dready", bus.d_req_ready, 1'b0);
      chk("bp_busy", bus.busy, 1'b1);
      tick();
    end
    quiet();
    bus.l2_req_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_l2v", bus.l2_req_valid, 1'b1);
    tick();
    quiet();
    bus.l2_resp_valid = 1'b1;
    @(negedge clk);
    chk("bp_drv", bus.d_resp_valid, 1'b1);
    chk("bp_irv", bus.i_resp_valid, 1'b0);
    tick();

    quiet();
    bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h5000;
    @(negedge clk);
    chk("rw_grant", bus.i_req_ready, 1'b1);
    tick();
    quiet();
    bus.l2_req_ready = 1'b1;
    tick();
    quiet();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.l2_resp_valid = 1'b1;
    @(negedge clk);
    chk("rw_irv", bus.i_resp_valid, 1'b0);
    chk("rw_drv", bus.d_resp_valid, 1'b0);
    chk("rw_busy", bus.busy, 1'b0);
    chk("rw_l2v", bus.l2_req_valid, 1'b0);
    chk("rw_l2addr", bus.l2_req_addr, 32'h0);
    tick();
    quiet();
    @(negedge clk);
    chk("rw_busy2", bus.busy, 1'b0);
    tick();

    bus.l2_resp_valid = 1'b1;
    @(negedge clk);
    chk("sp_irv", bus.i_resp_valid, 1'b0);
    chk("sp_drv", bus.d_resp_valid, 1'b0);
    chk("sp_irdata", bus.i_resp_data, 512'h0);
    tick();
    quiet();
    @(negedge clk);
    chk("sp_busy", bus.busy, 1'b0);
    chk("sp_l2v", bus.l2_req_valid, 1'b0);
    tick();

    do_reset();
    for (int k = 0; k < 6; k++) begin
      bus.i_req_valid = 1'b1; bus.d_req_valid = 1'b1;
      want_i = GUARD && (k % 3 == 2);
      @(negedge clk);
      chk($sformatf("sg%0d_i", k), bus.i_req_ready, want_i);
      chk($sformatf("sg%0d_d", k), bus.d_req_ready, !want_i);
      tick();
      bus.l2_req_ready = 1'b1;
      tick();
      bus.l2_req_ready = 1'b0; bus.l2_resp_valid = 1'b1;
      tick();
      bus.l2_resp_valid = 1'b0;
    end

    do_reset();
    piv = 1'b0; pdv = 1'b0; streak = 0;
    pi = newtxn(SRC_I); pd = newtxn(SRC_D);
    for (int n = 0; n < 2000; n++) begin
      if (!piv && $urandom_range(2) == 0) begin piv = 1'b1; pi = newtxn(SRC_I); end
      if (!pdv && $urandom_range(2) == 0) begin pdv = 1'b1; pd = newtxn(SRC_D); end
      lr = 1'($urandom_range(1));
      rv = to_resp.size() > 0 && $urandom_range(1) == 1;
      bus.i_req_valid = piv; bus.i_req_op = pi.op; bus.i_req_addr = pi.addr; bus.i_req_data = pi.data;
      bus.d_req_valid = pdv; bus.d_req_op = pd.op; bus.d_req_addr = pd.addr; bus.d_req_data = pd.data;
      bus.l2_req_ready = lr; bus.l2_resp_valid = rv; bus.l2_resp_data = rline();
      idle_m = to_l2.size() == 0 && to_resp.size() == 0;
      iwin = idle_m && piv && (!pdv || (GUARD && streak == SM));
      dwin = idle_m && pdv && !iwin;
      @(negedge clk);
      chk("rnd_iready", bus.i_req_ready, iwin);
      chk("rnd_dready", bus.d_req_ready, dwin);
      chk("rnd_busy", bus.busy, !idle_m);
      chk("rnd_l2v", bus.l2_req_valid, to_l2.size() > 0);
      if (to_l2.size() > 0) begin
        chk("rnd_l2op", bus.l2_req_op, to_l2[0].op);
        chk("rnd_l2addr", bus.l2_req_addr, to_l2[0].addr);
        chk("rnd_l2data", bus.l2_req_data, to_l2[0].data);
      end
      want_i = rv && to_resp[0].src == SRC_I;
      chk("rnd_irv", bus.i_resp_valid, want_i);
      chk("rnd_drv", bus.d_resp_valid, rv && !want_i);
      chk("rnd_irdata", bus.i_resp_data, want_i ? bus.l2_resp_data : 512'h0);
      chk("rnd_drdata", bus.d_resp_data, (rv && !want_i) ? bus.l2_resp_data : 512'h0);
      if (rv) void'(to_resp.pop_front());
      if (to_l2.size() > 0 && lr) to_resp.push_back(to_l2.pop_front());
      if (iwin) begin to_l2.push_back(pi); piv = 1'b0; streak = 0; end
      if (dwin) begin
        to_l2.push_back(pd); pdv = 1'b0;
        streak = piv ? (streak < SM ? streak + 1 : SM) : 0;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
